// File: rtl/d_memory_responder.sv
// Data-memory responder: accepts one load/store at a time, answers after LATENCY cycles.
// The word array is cleared by a sequential sweep after every reset.

`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

package d_memory_pkg;
   typedef enum logic [1:0] {
      MEM_LOAD  = 2'b00,
      MEM_STORE = 2'b01
   } memory_op_t;
endpackage

// state | meaning
// INIT  | clearing word init_idx_q, one word per cycle
// IDLE  | ready, waiting for a request
// WAIT  | request latched, counting down cnt_q
// RESP  | ack pulse; array access happened on the edge entering here
module d_memory_responder
   import d_memory_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             memory_req_valid,
   input  memory_op_t                       memory_req_op,
   input  logic [`D_MEMORY_ADDR_WIDTH-1:0]  memory_req_address,
   input  logic [`REG_VAL_WIDTH-1:0]        memory_req_data,
   output logic                             memory_ready,
   output logic                             memory_ack,
   output logic [`REG_VAL_WIDTH-1:0]        memory_data_return
);

   localparam int W     = `REG_VAL_WIDTH;
   localparam int OFS   = $clog2(W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] init_idx_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt_q;
   memory_op_t       op_q;
   logic [W-1:0]     wdata_q;
   logic [W-1:0]     rdata_q;
   logic [W-1:0]     mem_q [DEPTH];

   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] acc_idx;
   memory_op_t       acc_op;
   logic [W-1:0]     acc_data;
   logic             accept;
   logic             go_resp;
   logic             mem_we;
   logic [IDX_W-1:0] mem_widx;
   logic [W-1:0]     mem_wdata;
   logic             unused_addr_bits;

   // Offset bits below OFS and bits above the index are don't-care.
   assign req_idx          = memory_req_address[OFS +: IDX_W];
   assign unused_addr_bits = ^memory_req_address;

   assign accept  = (state_q == IDLE) && memory_req_valid;
   assign go_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == '0));

   // With LATENCY==1 the access happens on the accept edge itself, so use the live request.
   assign acc_op   = (state_q == IDLE) ? memory_req_op   : op_q;
   assign acc_idx  = (state_q == IDLE) ? req_idx         : idx_q;
   assign acc_data = (state_q == IDLE) ? memory_req_data : wdata_q;

   assign mem_we    = (state_q == INIT) || (go_resp && (acc_op == MEM_STORE));
   assign mem_widx  = (state_q == INIT) ? init_idx_q : acc_idx;
   assign mem_wdata = (state_q == INIT) ? '0 : acc_data;

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_widx] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         init_idx_q <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         op_q       <= MEM_LOAD;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            INIT: begin
               init_idx_q <= init_idx_q + 1'b1;
               if (init_idx_q == IDX_W'(DEPTH - 1)) state_q <= IDLE;
            end
            IDLE: begin
               if (memory_req_valid) begin
                  op_q    <= memory_req_op;
                  idx_q   <= req_idx;
                  wdata_q <= memory_req_data;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_W'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) state_q <= RESP;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= INIT;
         endcase
         if (go_resp && (acc_op == MEM_LOAD)) rdata_q <= mem_q[acc_idx];
      end
   end

   assign memory_ready       = (state_q == IDLE);
   assign memory_ack         = (state_q == RESP);
   assign memory_data_return = rdata_q;

endmodule

// File: tb/tb_d_memory_responder.sv
// Directed bench for d_memory_responder: main instance (DEPTH=256, LATENCY=2) plus
// LATENCY=1 and LATENCY=5 instances sharing the same request inputs.

module tb_d_memory_responder;
   import d_memory_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   memory_op_t  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        rdy, ack;
   logic [31:0] rdata;
   logic        rdy1, ack1;
   logic [31:0] rdata1;
   logic        rdy5, ack5;
   logic [31:0] rdata5;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   d_memory_responder #(.DEPTH(256), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n), .memory_req_valid(req_valid), .memory_req_op(req_op),
      .memory_req_address(req_addr), .memory_req_data(req_data),
      .memory_ready(rdy), .memory_ack(ack), .memory_data_return(rdata));

   d_memory_responder #(.DEPTH(16), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .memory_req_valid(req_valid), .memory_req_op(req_op),
      .memory_req_address(req_addr), .memory_req_data(req_data),
      .memory_ready(rdy1), .memory_ack(ack1), .memory_data_return(rdata1));

   d_memory_responder #(.DEPTH(16), .LATENCY(5)) dut_l5 (
      .clk(clk), .rst_n(rst_n), .memory_req_valid(req_valid), .memory_req_op(req_op),
      .memory_req_address(req_addr), .memory_req_data(req_data),
      .memory_ready(rdy5), .memory_ack(ack5), .memory_data_return(rdata5));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one request to the main instance; returns ack latency, data at ack,
   // and ack/ready one cycle after the ack. Ends just after a negedge.
   task automatic do_req(input memory_op_t op, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output logic [31:0] rd, output logic ack_after,
                         output logic rdy_after, output logic to);
      int n;
      to = 1'b0; lat = 0; rd = '0; ack_after = 1'b0; rdy_after = 1'b0;
      n = 0;
      while (rdy !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         to = 1'b1;
         return;
      end
      req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = MEM_LOAD; req_addr = '0; req_data = '0;
      do begin
         @(negedge clk);
         lat++;
      end while (ack !== 1'b1 && lat < 50);
      if (ack !== 1'b1) to = 1'b1;
      rd = rdata;
      @(negedge clk);
      ack_after = ack;
      rdy_after = rdy;
   endtask

   task automatic test_reset();
      int n, n16, init_acks, lat;
      logic [31:0] rd;
      logic a2, r2, to;
      rst_n = 1'b0; req_valid = 1'b0; req_op = MEM_LOAD; req_addr = '0; req_data = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rdy); end
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rdata); end
      rst_n = 1'b1;
      n = 0; n16 = -1; init_acks = 0;
      do begin
         @(negedge clk);
         n++;
         if (ack === 1'b1) init_acks++;
         if (n16 < 0 && rdy1 === 1'b1) n16 = n;
      end while (rdy !== 1'b1 && n < 400);
      n_checks++; if (n !== 256) begin n_fail++; $display("FAIL init_cycles: got %0d expected 256", n); end
      n_checks++; if (n16 !== 16) begin n_fail++; $display("FAIL init_cycles_depth16: got %0d expected 16", n16); end
      n_checks++; if (init_acks !== 0) begin n_fail++; $display("FAIL init_no_ack: got %0d expected 0", init_acks); end
      do_req(MEM_LOAD, 32'h40, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL load40_timeout: got %b expected 0", to); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL load40_data: got %h expected 0", rd); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load40_latency: got %0d expected 2", lat); end
      n_checks++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL load40_ack_width: got %b expected 0", a2); end
   endtask

   task automatic test_store_load();
      int lat;
      logic [31:0] rd;
      logic a2, r2, to;
      do_req(MEM_STORE, 32'h10, 32'hDEADBEEF, lat, rd, a2, r2, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL st10_timeout: got %b expected 0", to); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL st10_latency: got %0d expected 2", lat); end
      n_checks++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL st10_ready_after: got %b expected 1", r2); end
      n_checks++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL st10_ack_width: got %b expected 0", a2); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL st10_data_unchanged: got %h expected 0", rd); end
      do_req(MEM_LOAD, 32'h10, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld10_data: got %h expected deadbeef", rd); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ld10_latency: got %0d expected 2", lat); end
   endtask

   task automatic test_wrap();
      int lat;
      logic [31:0] rd;
      logic a2, r2, to;
      do_req(MEM_STORE, 32'h004, 32'h11, lat, rd, a2, r2, to);
      do_req(MEM_LOAD, 32'h407, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got %b expected 0", to); end
      n_checks++; if (rd !== 32'h11) begin n_fail++; $display("FAIL wrap_data: got %h expected 11", rd); end
   endtask

   task automatic test_other_op();
      int lat;
      logic [31:0] rd;
      logic a2, r2, to;
      do_req(memory_op_t'(2'b10), 32'h10, 32'h12345678, lat, rd, a2, r2, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL otherop_ack: timeout %b expected 0", to); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL otherop_latency: got %0d expected 2", lat); end
      n_checks++; if (rd !== 32'h11) begin n_fail++; $display("FAIL otherop_data_unchanged: got %h expected 11", rd); end
      do_req(MEM_LOAD, 32'h10, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL otherop_no_write: got %h expected deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      memory_op_t  ops   [5];
      logic [31:0] addrs [5];
      logic [31:0] datas [5];
      logic [31:0] expd  [5];
      logic [31:0] prev;
      int k, acks, last, gap_bad, extra;
      ops[0] = MEM_STORE; addrs[0] = 32'h100; datas[0] = 32'hA5A50001; expd[0] = 32'h0;
      ops[1] = MEM_LOAD;  addrs[1] = 32'h100; datas[1] = 32'h0;        expd[1] = 32'hA5A50001;
      ops[2] = MEM_STORE; addrs[2] = 32'h104; datas[2] = 32'h5A5A0002; expd[2] = 32'h0;
      ops[3] = MEM_LOAD;  addrs[3] = 32'h104; datas[3] = 32'h0;        expd[3] = 32'h5A5A0002;
      ops[4] = MEM_LOAD;  addrs[4] = 32'h100; datas[4] = 32'h0;        expd[4] = 32'hA5A50001;
      prev = 32'hDEADBEEF;
      k = 0; acks = 0; last = -1; gap_bad = 0;
      for (int c = 0; c < 40 && acks < 5; c++) begin
         if (c > 0) @(negedge clk);
         if (ack === 1'b1) begin
            if (ops[acks] == MEM_LOAD) begin
               n_checks++;
               if (rdata !== expd[acks]) begin n_fail++; $display("FAIL b2b_load%0d: got %h expected %h", acks, rdata, expd[acks]); end
               prev = expd[acks];
            end else begin
               n_checks++;
               if (rdata !== prev) begin n_fail++; $display("FAIL b2b_store%0d_data_hold: got %h expected %h", acks, rdata, prev); end
            end
            acks++;
         end
         if (rdy === 1'b1 && k < 5) begin
            if (last >= 0 && (c - last) != 3) gap_bad++;
            last = c;
            req_valid = 1'b1; req_op = ops[k]; req_addr = addrs[k]; req_data = datas[k];
            k++;
            @(posedge clk);
            #1;
            req_op = MEM_STORE; req_addr = 32'h100; req_data = 32'hBADBAD00;
         end
      end
      req_valid = 1'b0; req_op = MEM_LOAD; req_addr = '0; req_data = '0;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack === 1'b1) extra++;
      end
      n_checks++; if (acks !== 5) begin n_fail++; $display("FAIL b2b_ack_count: got %0d expected 5", acks); end
      n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL b2b_accept_spacing: got %0d bad gaps expected 0", gap_bad); end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_acks: got %0d expected 0", extra); end
   endtask

   task automatic test_latency();
      int n, l1, l2, l5, c1, c2, c5;
      logic r1_at2, r5_at5, r5_at6;
      logic [31:0] d1, d2, d5;
      for (int pass = 0; pass < 2; pass++) begin
         n = 0;
         while (!(rdy === 1'b1 && rdy1 === 1'b1 && rdy5 === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
         end
         n_checks++; if (n >= 100) begin n_fail++; $display("FAIL lat_all_ready: waited %0d cycles expected < 100", n); end
         req_valid = 1'b1;
         req_op    = (pass == 0) ? MEM_STORE : MEM_LOAD;
         req_addr  = 32'h8;
         req_data  = (pass == 0) ? 32'h77 : 32'h0;
         @(posedge clk);
         #1;
         req_valid = 1'b0; req_op = MEM_LOAD; req_addr = '0; req_data = '0;
         l1 = -1; l2 = -1; l5 = -1; c1 = 0; c2 = 0; c5 = 0;
         r1_at2 = 1'b0; r5_at5 = 1'b1; r5_at6 = 1'b0; d1 = '0; d2 = '0; d5 = '0;
         for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1) begin c1++; if (l1 < 0) begin l1 = i; d1 = rdata1; end end
            if (ack  === 1'b1) begin c2++; if (l2 < 0) begin l2 = i; d2 = rdata;  end end
            if (ack5 === 1'b1) begin c5++; if (l5 < 0) begin l5 = i; d5 = rdata5; end end
            if (i == 2) r1_at2 = rdy1;
            if (i == 5) r5_at5 = rdy5;
            if (i == 6) r5_at6 = rdy5;
         end
         if (pass == 0) begin
            n_checks++; if (l1 !== 1) begin n_fail++; $display("FAIL lat1_latency: got %0d expected 1", l1); end
            n_checks++; if (l2 !== 2) begin n_fail++; $display("FAIL lat2_latency: got %0d expected 2", l2); end
            n_checks++; if (l5 !== 5) begin n_fail++; $display("FAIL lat5_latency: got %0d expected 5", l5); end
            n_checks++; if (c1 !== 1) begin n_fail++; $display("FAIL lat1_ack_count: got %0d expected 1", c1); end
            n_checks++; if (c5 !== 1) begin n_fail++; $display("FAIL lat5_ack_count: got %0d expected 1", c5); end
            n_checks++; if (r1_at2 !== 1'b1) begin n_fail++; $display("FAIL lat1_ready_back: got %b expected 1", r1_at2); end
            n_checks++; if (r5_at5 !== 1'b0) begin n_fail++; $display("FAIL lat5_ready_during_ack: got %b expected 0", r5_at5); end
            n_checks++; if (r5_at6 !== 1'b1) begin n_fail++; $display("FAIL lat5_ready_back: got %b expected 1", r5_at6); end
         end else begin
            n_checks++; if (d1 !== 32'h77) begin n_fail++; $display("FAIL lat1_load: got %h expected 77", d1); end
            n_checks++; if (d2 !== 32'h77) begin n_fail++; $display("FAIL lat2_load: got %h expected 77", d2); end
            n_checks++; if (d5 !== 32'h77) begin n_fail++; $display("FAIL lat5_load: got %h expected 77", d5); end
            n_checks++; if (c2 !== 1) begin n_fail++; $display("FAIL lat2_ack_count: got %0d expected 1", c2); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int n, lat, acks;
      logic [31:0] rd;
      logic a2, r2, to;
      do_req(MEM_STORE, 32'h20, 32'hCAFEF00D, lat, rd, a2, r2, to);
      do_req(MEM_LOAD, 32'h20, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_pre_load: got %h expected cafef00d", rd); end
      n = 0;
      while (rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_op = MEM_STORE; req_addr = 32'h20; req_data = 32'h0BADF00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = MEM_LOAD; req_addr = '0; req_data = '0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0", rdy); end
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b expected 0", ack); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 0", rdata); end
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
      end
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (ack === 1'b1) acks++;
      end while (rdy !== 1'b1 && n < 400);
      n_checks++; if (n !== 256) begin n_fail++; $display("FAIL rst_mid_init_cycles: got %0d expected 256", n); end
      n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_ack_suppressed: got %0d acks expected 0", acks); end
      do_req(MEM_LOAD, 32'h20, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_load20: got %h expected 0", rd); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected 2", lat); end
      do_req(MEM_LOAD, 32'h10, 32'h0, lat, rd, a2, r2, to);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_load10: got %h expected 0", rd); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_wrap();
      test_other_op();
      test_back_to_back();
      test_latency();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/d_memory_responder.md
Name: d_memory_responder

Overview:
- Data-memory responder for the MEM side of the CPU–memory request interface: accepts one load/store request at a time, models a fixed access latency, and returns an ack pulse plus load data.
- Backs the LSU/commit path in simulation and integration; the CPU side connects through the interface's CPU modport, and this block drives the MEM modport signals.
- Internal word array is zero-initialised by a sequential sweep after reset.

Parameters:
- DEPTH, 256, number of REG_VAL_WIDTH-bit words; power of two, >=2.
- LATENCY, 2, cycles from request acceptance to ack; >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- memory_req_valid  in  1  request present
- memory_req_op  in  memory_op_t  MEM_LOAD or MEM_STORE
- memory_req_address  in  `D_MEMORY_ADDR_WIDTH  byte address
- memory_req_data  in  `REG_VAL_WIDTH  store data
- memory_ready  out  1  responder can accept a request this cycle
- memory_ack  out  1  one-cycle completion pulse
- memory_data_return  out  `REG_VAL_WIDTH  load result, valid while memory_ack=1

Behaviour:
- Reset (rst_n=0, async): state=INIT, init_idx=0, memory_ready=0, memory_ack=0, memory_data_return=0. Any in-flight request is dropped and no ack is issued for it.
- Address mapping: OFS=$clog2(`REG_VAL_WIDTH/8) low bits are ignored; word index = address[OFS +: $clog2(DEPTH)]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: INIT, IDLE, WAIT, RESP. All outputs are registered or decoded from state registers only.
- INIT:
  - Each cycle writes 0 to word init_idx, then increments init_idx.
  - After the write to DEPTH-1, the next state is IDLE.
  - memory_ready=0 throughout. INIT lasts exactly DEPTH cycles after reset release.
- IDLE:
  - memory_ready=1.
  - Accept occurs when memory_req_valid=1 in IDLE. At that edge, latch op, index and data.
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT:
  - memory_ready=0.
  - Decrement cnt. When cnt==0, go to RESP.
- RESP:
  - memory_ack=1, memory_ready=0, for exactly one cycle, then go to IDLE.
- Timing: if accept occurs at the edge ending cycle t, memory_ack is high in cycle t+LATENCY and memory_ready is high again in cycle t+LATENCY+1. Maximum throughput is one request per LATENCY+1 cycles.
- Load:
  - memory_data_return is registered from array[latched index] on the edge entering RESP.
  - It holds its value until the next load's RESP.
- Store:
  - The array write happens on the edge entering RESP. memory_data_return is unchanged.
  - A load in the following transaction observes the stored value.
- Op values other than MEM_LOAD/MEM_STORE: ack is still issued; there is no array access and memory_data_return is unchanged.
- memory_req_valid while memory_ready=0 is ignored; request fields are sampled only at accept.
- Only one request is outstanding at a time; there is no queueing.
- Reset during WAIT/RESP: ack is suppressed and the full INIT sweep is repeated; previously stored data is lost.

Test Plan:
- Reset release with DEPTH=256 -> memory_ready stays 0 for 256 cycles, then rises to 1. A load from address 0x40 returns 0 with memory_ack one cycle wide.
- LATENCY=2, REG_VAL_WIDTH=32: store 0xDEADBEEF to 0x10 accepted at cycle t -> ack at t+2, ready back at t+3. A subsequent load from 0x10 returns 0xDEADBEEF on its ack; data_return is unchanged during the store ack.
- Wrap/misalign (DEPTH=256, 32-bit): store 0x11 to 0x004, then load from 0x407 -> returns 0x11, since offset bits are ignored and the index wraps.
- memory_req_valid held high continuously with alternating store/load -> accepts occur only in IDLE, one per LATENCY+1 cycles; no duplicate acks; requests presented while ready=0 are not accepted.
- LATENCY=1 and LATENCY=5 builds -> ack exactly 1 and 5 cycles after accept respectively; WAIT is skipped for LATENCY=1.
- rst_n pulsed low during WAIT of a store to 0x20 -> no ack, INIT re-runs for DEPTH cycles, and a load from 0x20 afterwards returns 0.
